// File: rtl/pt8211_feeder.sv
// Sample FIFO feeding a 16-bit serial DAC.
// Generates the bit clock and loads one word per 32-bit frame.
module pt8211_feeder #(
   parameter int CLK_DIV = 4,
   parameter int FIFO_AW = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               bitclock,
   output logic [15:0]        dac_data,
   output logic               frame_tick,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               underrun,
   input  logic               clr_underrun
);

   localparam int HALF  = CLK_DIV / 2;
   localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL = DEPTH[FIFO_AW:0];
   localparam logic [HW-1:0]    HEND = HW'(HALF - 1);

   logic [HW-1:0]      half_cnt;
   logic [4:0]         frame_cnt;
   logic [FIFO_AW-1:0] wptr;
   logic [FIFO_AW-1:0] rptr;
   logic [15:0]        mem [DEPTH];

   logic half_end;
   logic fall;
   logic load;
   logic push;
   logic pop;
   logic starve;

   assign half_end = (half_cnt == HEND);
   assign fall     = half_end & bitclock;
   assign load     = fall & (frame_cnt == 5'd15);
   // Level is registered, so a same-cycle pop never frees a slot early
   assign in_ready = (fifo_level != FULL);
   assign push     = in_valid & in_ready;
   assign pop      = load & (fifo_level != '0);
   assign starve   = load & (fifo_level == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_cnt  <= '0;
         bitclock  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (half_end) begin
            half_cnt <= '0;
            bitclock <= ~bitclock;
         end else begin
            half_cnt <= half_cnt + 1'b1;
         end
         if (fall) begin
            frame_cnt <= frame_cnt + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_data   <= 16'h0000;
         frame_tick <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         frame_tick <= load;
         if (pop) begin
            dac_data <= mem[rptr];
         end
         // A starved load beats a simultaneous clear
         if (starve) begin
            underrun <= 1'b1;
         end else if (clr_underrun) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pt8211_feeder.sv
// Scoreboard bench for pt8211_feeder with a frame-level reference model.
module tb_pt8211_feeder;

   localparam int CLK_DIV = 4;
   localparam int FIFO_AW = 3;
   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int FIRST   = 16 * CLK_DIV;
   localparam int PERIOD  = 32 * CLK_DIV;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [15:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic             bitclock;
   logic [15:0]      dac_data;
   logic             frame_tick;
   logic [FIFO_AW:0] fifo_level;
   logic             underrun;
   logic             clr_underrun;

   pt8211_feeder #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .bitclock(bitclock),
      .dac_data(dac_data),
      .frame_tick(frame_tick),
      .fifo_level(fifo_level),
      .underrun(underrun),
      .clr_underrun(clr_underrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int unsigned cyc = 0;
   logic [15:0] mq[$];
   logic [15:0] sb[$];
   logic [15:0] dac_m = 16'h0000;
   logic        unr_m = 1'b0;
   bit          acc = 0;
   bit          ld_m;
   bit          rdy_m;
   bit          empty_m;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_load(int unsigned n);
      return (n >= FIRST) && (((n - FIRST) % PERIOD) == 0);
   endfunction

   // Model: cycles since reset release decide frame timing
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0;
         mq.delete();
         sb.delete();
         dac_m = 16'h0000;
         unr_m = 1'b0;
         acc = 0;
      end else begin
         cyc++;
         ld_m = is_load(cyc);
         empty_m = (mq.size() == 0);
         rdy_m = (mq.size() != DEPTH);
         acc = in_valid && rdy_m;
         if (ld_m) begin
            if (!empty_m) dac_m = mq.pop_front();
            sb.push_back(dac_m);
         end
         if (ld_m && empty_m) unr_m = 1'b1;
         else if (clr_underrun) unr_m = 1'b0;
         if (acc) mq.push_back(in_data);
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_bitclock", 32'(bitclock), 0);
         chk("rst_level", 32'(fifo_level), 0);
         chk("rst_dac", 32'(dac_data), 0);
      end else begin
         chk("frame_tick", 32'(frame_tick), 32'(sb.size() != 0));
         if (frame_tick && sb.size() != 0) begin
            chk("tick_dac", 32'(dac_data), 32'(sb.pop_front()));
         end
         sb.delete();
         chk("dac_hold", 32'(dac_data), 32'(dac_m));
         chk("level", 32'(fifo_level), 32'(mq.size()));
         chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
         chk("underrun", 32'(underrun), 32'(unr_m));
         chk("bitclock", 32'(bitclock), 32'((cyc / (CLK_DIV / 2)) % 2));
      end
   end

   task automatic wait_tick();
      for (int i = 0; i < 2 * PERIOD; i++) begin
         @(negedge clk);
         if (frame_tick) return;
      end
      chk("wait_tick_timeout", 1, 0);
   endtask

   task automatic wait_pre_load();
      for (int i = 0; i < 2 * PERIOD; i++) begin
         if (is_load(cyc + 1)) return;
         @(negedge clk);
      end
      chk("wait_load_timeout", 1, 0);
   endtask

   task automatic push_word(logic [15:0] d);
      in_valid = 1'b1;
      in_data = d;
      for (int i = 0; i < 4 * PERIOD; i++) begin
         @(negedge clk);
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      chk("push_timeout", 1, 0);
   endtask

   int cnt;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 16'h0;
      clr_underrun = 1'b0;
      #1;
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_tick", 32'(frame_tick), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle: starved ticks
      repeat (300) @(negedge clk);
      chk("idle_underrun", 32'(underrun), 1);
      chk("idle_dac", 32'(dac_data), 0);

      // Clear alone, then clear during a starved load
      wait_tick();
      clr_underrun = 1'b1;
      @(negedge clk);
      clr_underrun = 1'b0;
      chk("clr_alone", 32'(underrun), 0);
      wait_pre_load();
      clr_underrun = 1'b1;
      @(negedge clk);
      clr_underrun = 1'b0;
      chk("clr_vs_set", 32'(underrun), 1);

      // Three back-to-back samples
      push_word(16'h1234);
      push_word(16'h8000);
      push_word(16'h7FFF);
      chk("b2b_level", 32'(fifo_level), 3);
      wait_tick();
      chk("b2b_dac0", 32'(dac_data), 32'h1234);
      chk("b2b_lvl0", 32'(fifo_level), 2);
      wait_tick();
      chk("b2b_dac1", 32'(dac_data), 32'h8000);
      chk("b2b_lvl1", 32'(fifo_level), 1);
      wait_tick();
      chk("b2b_dac2", 32'(dac_data), 32'h7FFF);
      chk("b2b_lvl2", 32'(fifo_level), 0);

      // Fill to full, ninth held off across a load
      wait_tick();
      for (int i = 0; i < DEPTH; i++) push_word(16'hA000 + 16'(i));
      chk("full_level", 32'(fifo_level), 8);
      chk("full_ready", 32'(in_ready), 0);
      in_valid = 1'b1;
      in_data = 16'hBEEF;
      wait_pre_load();
      @(negedge clk);
      chk("full_pop_lvl", 32'(fifo_level), 7);
      chk("full_refused", 32'(acc), 0);
      @(negedge clk);
      chk("full_accept", 32'(acc), 1);
      chk("full_refill", 32'(fifo_level), 8);
      in_valid = 1'b0;
      repeat (DEPTH + 1) wait_tick();
      chk("drained", 32'(fifo_level), 0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         in_valid = ($urandom_range(0, 99) < 4);
         in_data = 16'($urandom);
         clr_underrun = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      clr_underrun = 1'b0;
      repeat (DEPTH + 1) wait_tick();

      // Mid-frame reset with five queued
      wait_tick();
      for (int i = 0; i < 5; i++) push_word(16'hC000 + 16'(i));
      for (int i = 0; i < PERIOD; i++) begin
         if (((cyc / CLK_DIV) % 32) == 20) break;
         @(negedge clk);
      end
      chk("pre_rst_level", 32'(fifo_level), 5);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_level", 32'(fifo_level), 0);
      chk("mid_rst_ready", 32'(in_ready), 1);
      chk("mid_rst_bclk", 32'(bitclock), 0);
      chk("mid_rst_dac", 32'(dac_data), 0);
      chk("mid_rst_unr", 32'(underrun), 0);
      chk("mid_rst_tick", 32'(frame_tick), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!frame_tick && cnt < 300);
      chk("post_rst_tick", 32'(cnt), 32'(FIRST));
      chk("post_rst_unr", 32'(underrun), 1);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pt8211_feeder.md
PT8211_FEEDER -- requirements
Module: pt8211_feeder

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per bitclock period; even, >= 2.
REQ-002 Parameter FIFO_AW, default 3, FIFO address width; depth = 2**FIFO_AW samples.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  16  signed PCM sample from the producer.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  FIFO accepts a sample this cycle.
REQ-008 bitclock  output  1  registered serial bit clock to the DAC serializer.
REQ-009 dac_data  output  16  sample word presented to the DAC serializer.
REQ-010 frame_tick  output  1  one-clk pulse on each load event.
REQ-011 fifo_level  output  FIFO_AW+1  number of samples currently stored.
REQ-012 underrun  output  1  sticky flag: a load event found the FIFO empty.
REQ-013 clr_underrun  input  1  synchronous clear of underrun.

Function
REQ-014 bitclock SHALL toggle every CLK_DIV/2 clk cycles using a half-period counter; 50% duty.
REQ-015 A falling edge is the clk cycle in which the bitclock register changes 1->0.
REQ-016 frame_cnt (5 bit, internal) SHALL increment on every falling edge and wrap 31->0.
REQ-017 Load event = the falling edge at which frame_cnt changes 15->16; exactly one per 32 bitclocks.
REQ-018 Push SHALL occur when in_valid && in_ready; in_ready = (fifo_level != 2**FIFO_AW).
REQ-019 On a load event with fifo_level != 0 the FIFO head SHALL be popped and written to dac_data in the same clk cycle.
REQ-020 dac_data SHALL change only on load events; it is stable for 32 bitclocks, including across the frame_cnt 31->0 edge.
REQ-021 On a load event with fifo_level == 0, dac_data SHALL hold its previous value and underrun SHALL set.
REQ-022 A push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-023 A sample pushed in the same cycle as a load event on an empty FIFO SHALL NOT be popped by that event.
REQ-024 When full, a push SHALL be refused even if a pop occurs in the same cycle, because in_ready is derived from the registered level.
REQ-025 Read and write pointers are FIFO_AW bits and wrap modulo depth; fifo_level is a separate counter.
REQ-026 Samples SHALL leave the FIFO in push order, with no loss or duplication except the hold in REQ-021.
REQ-027 frame_tick SHALL be high for exactly the load-event cycle, whether or not an underrun occurred.
REQ-028 If clr_underrun and a new underrun coincide, underrun SHALL remain 1 (set wins).
REQ-029 Minimum latency: a sample pushed into an empty FIFO appears on dac_data at the next load event, which is at least 1 clk later.

Reset
REQ-030 On rst_n low, asynchronously: bitclock=0, half-period counter=0, frame_cnt=0, pointers=0, fifo_level=0, dac_data=16'h0000, frame_tick=0, underrun=0; in_ready therefore =1.
REQ-031 A reset asserted mid-frame SHALL discard all FIFO contents and restart framing.
REQ-032 After rst_n rises, the first bitclock rising edge SHALL occur CLK_DIV/2 clk cycles later, and the first load event on the 16th falling edge.

Verification (CLK_DIV=4, FIFO_AW=3)
REQ-033 Release reset, no pushes -> bitclock period 4 clk; frame_tick every 128 clk; the first tick sets underrun=1; dac_data stays 0x0000.
REQ-034 Push 0x1234, 0x8000, 0x7FFF back-to-back -> dac_data takes 0x1234, 0x8000, 0x7FFF on three successive ticks; fifo_level goes 3,2,1,0.
REQ-035 Push 9 samples continuously from empty, no tick in between -> in_ready=0 after the 8th; the 9th is held off and accepted after the next pop.
REQ-036 Full FIFO, in_valid=1 held through a load event -> the pop takes effect, the push is refused that cycle and accepted the cycle after; fifo_level goes 8,7,8.
REQ-037 Hold underrun=1, then pulse clr_underrun alone -> 0; pulse it in a starved tick cycle -> stays 1.
REQ-038 Drop rst_n at frame_cnt=20 with 5 samples queued -> all outputs at reset values immediately; fifo_level=0; the next tick is 16 bitclocks after release.
